// File: rtl/io_out_pkg.sv
// io_out_pkg: shared constants and types for the memory-mapped output block.
//   NUM_DIGITS  - digits on the multiplexed seven-segment display
//   SEG_BLANK   - cathode pattern with every segment (and dp) off
//   ANODE_OFF   - anode pattern with every digit off
//   SEG_HEX     - active-low {dp,g,f,e,d,c,b,a} patterns for nibbles 0..F, dp off
//   wr_target() - resolves one store into at most one destination register.
//                 Chip-select priority: led_cs > seg_cs > blank_cs.
package io_out_pkg;

    localparam int         NUM_DIGITS = 8;
    localparam logic [7:0] SEG_BLANK  = 8'hFF;
    localparam logic [7:0] ANODE_OFF  = 8'hFF;

    localparam logic [7:0] SEG_HEX [0:15] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    typedef enum logic [1:0] {
        WR_NONE,
        WR_LED,
        WR_SEG,
        WR_BLANK
    } wr_target_e;

    // Several selects in one store is a decoder fault; resolve it
    // deterministically so only one register ever changes per store.
    function automatic wr_target_e wr_target(input logic mem_write,
                                             input logic led_cs,
                                             input logic seg_cs,
                                             input logic blank_cs);
        if (!mem_write)    return WR_NONE;
        else if (led_cs)   return WR_LED;
        else if (seg_cs)   return WR_SEG;
        else if (blank_cs) return WR_BLANK;
        else               return WR_NONE;
    endfunction

endpackage

// File: rtl/io_out_ctrl_seg_hex_decode.sv
// seg_hex_decode: combinational hex-digit to seven-segment decoder.
//   nibble  in  4  hex value to display
//   pattern out 8  active-low cathodes {dp,g,f,e,d,c,b,a}, dp always off
module seg_hex_decode
    import io_out_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] pattern
);

    assign pattern = SEG_HEX[nibble];

endmodule

// File: rtl/io_out_ctrl.sv
// io_out_ctrl: store-side output registers for LEDs and an 8-digit
// multiplexed seven-segment display, plus the display scan.
//   clk       in   1  system clock, rising edge
//   rst       in   1  asynchronous active-high reset
//   mem_write in   1  CPU store strobe
//   led_cs    in   1  store targets LED register
//   seg_cs    in   1  store targets display data register (8 nibbles)
//   blank_cs  in   1  store targets per-digit blank mask
//   data      in  32  CPU store data
//   led       out 16  LED drive, active-high
//   an        out  8  digit anodes, active-low, one-hot-low while scanning
//   seg       out  8  cathodes {dp,g,f,e,d,c,b,a}, active-low
module io_out_ctrl
    import io_out_pkg::*;
#(
    parameter int SCAN_CNT_MAX = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_write,
    input  logic        led_cs,
    input  logic        seg_cs,
    input  logic        blank_cs,
    input  logic [31:0] data,
    output logic [15:0] led,
    output logic [7:0]  an,
    output logic [7:0]  seg
);

    localparam int               CNT_W    = $clog2(SCAN_CNT_MAX);
    localparam int               IDX_W    = $clog2(NUM_DIGITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_CNT_MAX - 1);

    logic [CNT_W-1:0] scan_cnt;
    logic [IDX_W-1:0] digit_idx;
    logic [31:0]      seg_reg;
    logic [7:0]       blank_reg;
    wr_target_e       wr_sel;
    logic [3:0]       nibble;
    logic [7:0]       hex_pattern;
    logic [7:0]       an_next;
    logic [7:0]       seg_next;

    assign wr_sel = wr_target(mem_write, led_cs, seg_cs, blank_cs);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led       <= 16'h0000;
            seg_reg   <= 32'h0;
            blank_reg <= 8'h00;
        end else begin
            case (wr_sel)
                WR_LED:   led       <= data[15:0];
                WR_SEG:   seg_reg   <= data;
                WR_BLANK: blank_reg <= data[7:0];
                default:  ;
            endcase
        end
    end

    // Free-running scan; store traffic has no path into it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt  <= '0;
            digit_idx <= '0;
        end else if (scan_cnt == CNT_LAST) begin
            scan_cnt  <= '0;
            digit_idx <= digit_idx + 1'b1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    assign nibble = seg_reg[{digit_idx, 2'b00} +: 4];

    seg_hex_decode u_seg_hex_decode (
        .nibble  (nibble),
        .pattern (hex_pattern)
    );

    assign an_next  = ~(8'b1 << digit_idx);
    assign seg_next = blank_reg[digit_idx] ? SEG_BLANK : hex_pattern;

    // an and seg share one register stage so digit and pattern switch together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an  <= ANODE_OFF;
            seg <= SEG_BLANK;
        end else begin
            an  <= an_next;
            seg <= seg_next;
        end
    end

endmodule

// File: tb/tb_io_out_ctrl.sv
module tb_io_out_ctrl;

    localparam int SCAN = 4;

    typedef struct packed {
        logic [7:0] an;
        logic [7:0] seg;
    } disp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_write = 1'b0;
    logic        led_cs = 1'b0;
    logic        seg_cs = 1'b0;
    logic        blank_cs = 1'b0;
    logic [31:0] data = 32'h0;
    logic [15:0] led;
    logic [7:0]  an;
    logic [7:0]  seg;

    int checks = 0;
    int errors = 0;

    disp_t       disp_q[$];
    logic [15:0] led_q[$];

    io_out_ctrl #(.SCAN_CNT_MAX(SCAN)) dut (
        .clk       (clk),
        .rst       (rst),
        .mem_write (mem_write),
        .led_cs    (led_cs),
        .seg_cs    (seg_cs),
        .blank_cs  (blank_cs),
        .data      (data),
        .led       (led),
        .an        (an),
        .seg       (seg)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: return 8'hC0; 4'h1: return 8'hF9; 4'h2: return 8'hA4; 4'h3: return 8'hB0;
            4'h4: return 8'h99; 4'h5: return 8'h92; 4'h6: return 8'h82; 4'h7: return 8'hF8;
            4'h8: return 8'h80; 4'h9: return 8'h90; 4'hA: return 8'h88; 4'hB: return 8'h83;
            4'hC: return 8'hC6; 4'hD: return 8'hA1; 4'hE: return 8'h86; default: return 8'h8E;
        endcase
    endfunction

    // Expected display for edge e (1 = first edge after reset release),
    // given the register contents that edge sees.
    function automatic disp_t exp_disp(input int e, input logic [31:0] sv, input logic [7:0] bv);
        disp_t d;
        int    dig;
        dig   = ((e - 1) / SCAN) % 8;
        d.an  = ~(8'b1 << dig);
        d.seg = bv[dig] ? 8'hFF : hex7(sv[dig*4 +: 4]);
        return d;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stim();
        mem_write = 1'b0; led_cs = 1'b0; seg_cs = 1'b0; blank_cs = 1'b0; data = 32'h0;
    endtask

    // Leaves rst released just after an edge; the next edge is edge 1.
    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        tick();
        checks++;
        if (led !== 16'h0000 || an !== 8'hFF || seg !== 8'hFF) begin
            errors++;
            $display("FAIL reset_state: led=%h an=%h seg=%h required 0000/FF/FF", led, an, seg);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (an !== 8'hFE || seg !== 8'hC0) begin
            errors++;
            $display("FAIL reset_release: an=%h seg=%h required FE/C0", an, seg);
        end
        mem_write = 1'b1; led_cs = 1'b1; data = 32'h0000_5A5A;
        tick();
        clear_stim();
        checks++;
        if (led !== 16'h5A5A) begin
            errors++;
            $display("FAIL reset_pre_led: led=%h required 5A5A", led);
        end
        #3 rst = 1'b1;
        #1;
        checks++;
        if (led !== 16'h0000 || an !== 8'hFF || seg !== 8'hFF) begin
            errors++;
            $display("FAIL reset_async: led=%h an=%h seg=%h required 0000/FF/FF", led, an, seg);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_led();
        logic [15:0] exp;
        do_reset();
        mem_write = 1'b1; led_cs = 1'b1; data = 32'hDEAD_BEEF;
        led_q.push_back(16'hBEEF);
        tick();
        exp = led_q.pop_front();
        checks++;
        if (led !== exp) begin
            errors++;
            $display("FAIL led_store: led=%h required %h", led, exp);
        end
        mem_write = 1'b0; led_cs = 1'b1; data = 32'h0;
        led_q.push_back(16'hBEEF);
        tick();
        exp = led_q.pop_front();
        checks++;
        if (led !== exp) begin
            errors++;
            $display("FAIL led_no_write: led=%h required %h", led, exp);
        end
        mem_write = 1'b1; led_cs = 1'b0; seg_cs = 1'b1; data = 32'h0000_1111;
        led_q.push_back(16'hBEEF);
        tick();
        clear_stim();
        exp = led_q.pop_front();
        checks++;
        if (led !== exp) begin
            errors++;
            $display("FAIL led_other_cs: led=%h required %h", led, exp);
        end
    endtask

    task automatic test_scan();
        disp_t exp;
        do_reset();
        disp_q.push_back(exp_disp(1, 32'h0, 8'h00));
        for (int e = 2; e <= 36; e++) disp_q.push_back(exp_disp(e, 32'h0123_4567, 8'h00));
        mem_write = 1'b1; seg_cs = 1'b1; data = 32'h0123_4567;
        for (int k = 1; k <= 36; k++) begin
            tick();
            if (k == 1) clear_stim();
            exp = disp_q.pop_front();
            checks++;
            if (an !== exp.an || seg !== exp.seg) begin
                errors++;
                $display("FAIL scan edge %0d: an=%h seg=%h required an=%h seg=%h",
                         k, an, seg, exp.an, exp.seg);
            end
        end
    endtask

    task automatic test_blank_and_priority();
        disp_t       exp;
        logic [15:0] lexp;
        do_reset();
        disp_q.push_back(exp_disp(1, 32'h0, 8'h00));
        disp_q.push_back(exp_disp(2, 32'h8888_8888, 8'h00));
        for (int e = 3; e <= 64; e++) disp_q.push_back(exp_disp(e, 32'h8888_8888, 8'h0F));
        mem_write = 1'b1; seg_cs = 1'b1; data = 32'h8888_8888;
        for (int k = 1; k <= 64; k++) begin
            tick();
            if (k == 1) begin
                seg_cs = 1'b0; blank_cs = 1'b1; data = 32'h0000_000F;
            end else if (k == 32) begin
                mem_write = 1'b1; led_cs = 1'b1; seg_cs = 1'b1; blank_cs = 1'b1;
                data = 32'h0000_1234;
                led_q.push_back(16'h1234);
            end else begin
                clear_stim();
            end
            if (k == 33) begin
                lexp = led_q.pop_front();
                checks++;
                if (led !== lexp) begin
                    errors++;
                    $display("FAIL multi_cs_led: led=%h required %h", led, lexp);
                end
            end
            exp = disp_q.pop_front();
            checks++;
            if (an !== exp.an || seg !== exp.seg) begin
                errors++;
                $display("FAIL blank edge %0d: an=%h seg=%h required an=%h seg=%h",
                         k, an, seg, exp.an, exp.seg);
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        disp_t exp;
        do_reset();
        mem_write = 1'b1; seg_cs = 1'b1; data = 32'h0123_4567;
        tick();
        clear_stim();
        // 22 edges since release: digit index 5, counter 2.
        for (int k = 2; k <= 22; k++) tick();
        checks++;
        if (an !== 8'hDF) begin
            errors++;
            $display("FAIL mid_scan_pos: an=%h required DF", an);
        end
        #3 rst = 1'b1;
        #1;
        checks++;
        if (an !== 8'hFF || seg !== 8'hFF) begin
            errors++;
            $display("FAIL mid_scan_async: an=%h seg=%h required FF/FF", an, seg);
        end
        tick();
        rst = 1'b0;
        for (int e = 1; e <= 8; e++) disp_q.push_back(exp_disp(e, 32'h0, 8'h00));
        for (int k = 1; k <= 8; k++) begin
            tick();
            exp = disp_q.pop_front();
            checks++;
            if (an !== exp.an || seg !== exp.seg) begin
                errors++;
                $display("FAIL mid_scan_restart edge %0d: an=%h seg=%h required an=%h seg=%h",
                         k, an, seg, exp.an, exp.seg);
            end
        end
    endtask

    initial begin
        test_reset();
        test_led();
        test_scan();
        test_blank_and_priority();
        test_reset_mid_scan();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
